// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding and timing constants for the sort controller
package sort_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SORT_START, SORT_WAIT, UNLOAD} state_t;
    localparam int DONE_BLANK = 2;
endpackage

// File: rtl/sort_ctrl_if.sv
// sort_ctrl_if: Avalon-ST style word stream with packet delimiters
interface sort_ctrl_if #(parameter int DWIDTH = 10);
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
    logic              valid;
    logic              ready;
    modport master (output data, sop, eop, valid, input ready);
    modport slave  (input data, sop, eop, valid, output ready);
endinterface

// File: rtl/sort_out_skid.sv
// sort_out_skid: two-entry output FIFO holding sorted words with their packet tags
module sort_out_skid #(parameter int W = 12) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] i_data,
    input  logic         i_push,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) r_mem[r_wp] <= i_data;
            r_wp  <= r_wp ^ i_push;
            r_rp  <= r_rp ^ i_pop;
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
        end
    end
    assign o_data  = r_mem[r_rp];
    assign o_valid = r_cnt != 2'd0;
    assign o_count = r_cnt;
endmodule

// File: rtl/sort_ctrl.sv
// sort_ctrl: loads a packet into the shared RAM, kicks the sorter, then streams the sorted words out
module sort_ctrl import sort_pkg::*; #(
    parameter int DWIDTH  = 10,
    parameter int ADDR_SZ = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sort_ctrl_if.slave         snk,
    sort_ctrl_if.master        src,
    input  logic [ADDR_SZ-1:0] srt_address_a_i,
    input  logic [ADDR_SZ-1:0] srt_address_b_i,
    input  logic [DWIDTH-1:0]  srt_data_a_i,
    input  logic [DWIDTH-1:0]  srt_data_b_i,
    input  logic               srt_wren_a_i,
    input  logic               srt_wren_b_i,
    output logic [DWIDTH-1:0]  srt_q_a_o,
    output logic [DWIDTH-1:0]  srt_q_b_o,
    output logic               srt_sorting_o,
    output logic [ADDR_SZ-1:0] srt_max_counter_o,
    input  logic               srt_done_i,
    output logic [ADDR_SZ-1:0] ram_address_a_o,
    output logic [ADDR_SZ-1:0] ram_address_b_o,
    output logic [DWIDTH-1:0]  ram_data_a_o,
    output logic [DWIDTH-1:0]  ram_data_b_o,
    output logic               ram_wren_a_o,
    output logic               ram_wren_b_o,
    input  logic [DWIDTH-1:0]  ram_q_a_i,
    input  logic [DWIDTH-1:0]  ram_q_b_i,
    output logic               overflow_o
);
    localparam int CW = ADDR_SZ + 1;
    localparam logic [CW-1:0] MAX_LEN = {1'b1, {ADDR_SZ{1'b0}}};
    state_t              r_state;
    logic [CW-1:0]       r_wr_cnt, r_n, r_rd_cnt, r_push_cnt;
    logic                r_wren, r_sorting, r_ovf, r_q_vld, r_pend, r_have;
    logic [ADDR_SZ-1:0]  r_waddr, r_max;
    logic [DWIDTH-1:0]   r_wdata, r_hold;
    logic [1:0]          r_blank;
    logic                w_sw, w_acc, w_fit, w_wr, w_n2, w_pop, w_rd, w_push, w_valid;
    logic [CW-1:0]       w_base, w_n;
    logic [DWIDTH-1:0]   w_lo, w_hi, w_pdata;
    logic [DWIDTH+1:0]   w_out;
    logic [1:0]          w_cnt;
    assign snk.ready = (r_state == IDLE) | (r_state == LOAD);
    assign w_acc     = snk.valid & snk.ready & (snk.sop | (r_state == LOAD));
    assign w_base    = snk.sop ? '0 : r_wr_cnt;
    assign w_fit     = w_base < MAX_LEN;
    assign w_wr      = w_acc & w_fit;
    assign w_n       = w_wr ? w_base + CW'(1) : w_base;
    assign w_n2      = r_n == CW'(2);
    assign w_pop     = w_valid & src.ready;
    // a read may be issued when its data will find a free slot, crediting this cycle's pop
    assign w_rd      = (r_state == UNLOAD) & !r_wren & (r_rd_cnt < r_n) &
                       (({1'b0, w_cnt} + {2'b0, r_q_vld}) < (3'd2 + {2'b0, w_pop}));
    assign w_lo      = (r_hold < ram_q_a_i) ? r_hold : ram_q_a_i;
    assign w_hi      = (r_hold < ram_q_a_i) ? ram_q_a_i : r_hold;
    assign w_push    = r_pend | (r_q_vld & !(w_n2 & !r_have));
    assign w_pdata   = r_pend ? r_hold : (w_n2 ? w_lo : ram_q_a_i);
    sort_out_skid #(.W(DWIDTH + 2)) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_data  ({r_push_cnt == r_n - CW'(1), r_push_cnt == '0, w_pdata}),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .o_data  (w_out),
        .o_valid (w_valid),
        .o_count (w_cnt)
    );
    assign src.data  = w_out[DWIDTH-1:0];
    assign src.sop   = w_valid & w_out[DWIDTH];
    assign src.eop   = w_valid & w_out[DWIDTH+1];
    assign src.valid = w_valid;
    assign w_sw            = r_state == SORT_WAIT;
    assign ram_address_a_o = w_sw ? srt_address_a_i : (r_wren ? r_waddr : r_rd_cnt[ADDR_SZ-1:0]);
    assign ram_data_a_o    = w_sw ? srt_data_a_i : r_wdata;
    assign ram_wren_a_o    = w_sw ? srt_wren_a_i : r_wren;
    assign ram_address_b_o = w_sw ? srt_address_b_i : '0;
    assign ram_data_b_o    = w_sw ? srt_data_b_i : '0;
    assign ram_wren_b_o    = w_sw & srt_wren_b_i;
    assign srt_q_a_o         = ram_q_a_i;
    assign srt_q_b_o         = ram_q_b_i;
    assign srt_sorting_o     = r_sorting;
    assign srt_max_counter_o = r_max;
    assign overflow_o        = r_ovf;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_wr_cnt   <= '0;
            r_n        <= '0;
            r_rd_cnt   <= '0;
            r_push_cnt <= '0;
            r_wren     <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_sorting  <= 1'b0;
            r_max      <= '0;
            r_blank    <= 2'd0;
            r_ovf      <= 1'b0;
            r_q_vld    <= 1'b0;
            r_pend     <= 1'b0;
            r_have     <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_wren    <= w_wr;
            r_waddr   <= w_base[ADDR_SZ-1:0];
            r_wdata   <= snk.data;
            r_sorting <= 1'b0;
            r_q_vld   <= w_rd;
            r_pend    <= 1'b0;
            if (w_rd) r_rd_cnt <= r_rd_cnt + CW'(1);
            if (w_push) r_push_cnt <= r_push_cnt + CW'(1);
            // two-word packets: hold the first word, emit min then max
            if (r_q_vld & w_n2) begin
                r_have <= 1'b1;
                r_hold <= r_have ? w_hi : ram_q_a_i;
                r_pend <= r_have;
            end
            case (r_state)
                IDLE, LOAD: if (w_acc) begin
                    r_wr_cnt <= w_n;
                    r_ovf    <= !w_fit | (r_ovf & !snk.sop);
                    r_state  <= LOAD;
                    if (snk.eop) begin
                        r_n        <= w_n;
                        r_rd_cnt   <= '0;
                        r_push_cnt <= '0;
                        r_have     <= 1'b0;
                        r_max      <= ADDR_SZ'(w_n - CW'(1));
                        r_sorting  <= w_n >= CW'(3);
                        r_blank    <= 2'(DONE_BLANK);
                        r_state    <= (w_n >= CW'(3)) ? SORT_START : UNLOAD;
                    end
                end
                SORT_START: r_state <= SORT_WAIT;
                SORT_WAIT: if (r_blank != 2'd0) r_blank <= r_blank - 2'd1;
                           else if (srt_done_i) r_state <= UNLOAD;
                UNLOAD: if (w_pop & src.eop) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_ctrl.sv
// tb_sort_ctrl: random packets against a queue-based sorting reference, with a stand-in sorter and RAM
module tb_sort_ctrl;
    localparam int DW = 10, AW = 4, MAX = 16;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    sort_ctrl_if #(.DWIDTH(DW)) snk();
    sort_ctrl_if #(.DWIDTH(DW)) src();
    logic [AW-1:0] sa_a, sa_b, maxc, ra_a, ra_b;
    logic [DW-1:0] sd_a, sd_b, sq_a, sq_b, rd_a, rd_b, rq_a, rq_b;
    logic          sw_a, sw_b, sorting, done, rw_a, rw_b, ovf;
    logic [DW-1:0] mem [MAX];
    sort_ctrl #(.DWIDTH(DW), .ADDR_SZ(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .snk(snk), .src(src),
        .srt_address_a_i(sa_a), .srt_address_b_i(sa_b), .srt_data_a_i(sd_a), .srt_data_b_i(sd_b),
        .srt_wren_a_i(sw_a), .srt_wren_b_i(sw_b), .srt_q_a_o(sq_a), .srt_q_b_o(sq_b),
        .srt_sorting_o(sorting), .srt_max_counter_o(maxc), .srt_done_i(done),
        .ram_address_a_o(ra_a), .ram_address_b_o(ra_b), .ram_data_a_o(rd_a), .ram_data_b_o(rd_b),
        .ram_wren_a_o(rw_a), .ram_wren_b_o(rw_b), .ram_q_a_i(rq_a), .ram_q_b_i(rq_b),
        .overflow_o(ovf)
    );
    always @(posedge clk) begin
        if (rw_a) mem[ra_a] <= rd_a;
        if (rw_b) mem[ra_b] <= rd_b;
        rq_a <= mem[ra_a];
        rq_b <= mem[ra_b];
    end
    int checks = 0, fails = 0, pulses = 0, last_max = -1;
    int exp_q[$], got_q[$];
    int exp_max, exp_ovf, exp_pulse;
    bit rand_ready = 0;
    logic [DW-1:0] pkt [32];
    int pn, pmid;
    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask
    always @(posedge clk) begin
        #1 src.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bit stall = 0;
    int prev;
    always @(negedge clk) begin
        if (!rst_n) stall = 0;
        else begin
            if (stall) chk("stall_hold", {src.valid, src.eop, src.sop, src.data}, prev);
            if (src.valid && src.ready) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else chk("out_word", {src.eop, src.sop, src.data}, exp_q.pop_front());
                got_q.push_back(int'(src.data));
            end
            stall = src.valid && !src.ready;
            prev  = {src.valid, src.eop, src.sop, src.data};
            if (sorting) begin
                pulses++;
                last_max = int'(maxc);
                chk("max_counter", int'(maxc), exp_max);
            end
        end
    end
    task automatic sorter();
        int m;
        int v [MAX];
        int t;
        m = int'(maxc);
        repeat (3) begin
            @(negedge clk);
            if (!rst_n) return;
        end
        done = 1'b0;
        for (int i = 0; i <= m; i++) begin
            sa_a = AW'(i);
            @(negedge clk);
            if (!rst_n) return;
            v[i] = int'(sq_a);
        end
        for (int i = 0; i <= m; i++)
            for (int j = 0; j < m - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        for (int i = 0; i <= m; i += 2) begin
            sa_a = AW'(i); sd_a = DW'(v[i]); sw_a = 1'b1;
            sa_b = AW'(i + 1); sd_b = DW'(v[(i + 1) % MAX]); sw_b = (i + 1 <= m);
            @(negedge clk);
            if (!rst_n) begin sw_a = 1'b0; sw_b = 1'b0; return; end
        end
        sw_a = 1'b0; sw_b = 1'b0;
        done = 1'b1;
    endtask
    initial begin
        done = 1'b1; sw_a = 1'b0; sw_b = 1'b0; sa_a = '0; sa_b = '0; sd_a = '0; sd_b = '0;
        forever begin
            @(negedge clk);
            if (rst_n && sorting) sorter();
        end
    end
    task automatic model_pkt();
        int l[$];
        int t;
        exp_ovf = 0;
        for (int i = 0; i < pn; i++) begin
            if (i == 0 || i == pmid) begin l.delete(); exp_ovf = 0; end
            if (l.size() < MAX) l.push_back(int'(pkt[i]));
            else exp_ovf = 1;
        end
        for (int i = 0; i < l.size(); i++)
            for (int j = 0; j + 1 < l.size() - i; j++)
                if (l[j] > l[j+1]) begin t = l[j]; l[j] = l[j+1]; l[j+1] = t; end
        for (int i = 0; i < l.size(); i++)
            exp_q.push_back({(i == l.size() - 1), (i == 0), l[i][DW-1:0]});
        exp_max   = l.size() - 1;
        exp_pulse = (l.size() >= 3);
    endtask
    task automatic send(input bit gaps);
        int k;
        for (int i = 0; i < pn; i++) begin
            if (gaps) begin
                snk.valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            snk.valid = 1'b1; snk.data = pkt[i];
            snk.sop = (i == 0 || i == pmid); snk.eop = (i == pn - 1);
            k = 0;
            while (!snk.ready && k < 100) begin @(negedge clk); k++; end
            if (k == 100) chk("snk_ready_timeout", 0, 1);
            @(negedge clk);
        end
        snk.valid = 1'b0; snk.sop = 1'b0; snk.eop = 1'b0;
    endtask
    task automatic run_pkt(input bit gaps, input bit meas);
        int p0, k, c;
        p0 = pulses;
        got_q.delete();
        model_pkt();
        send(gaps);
        if (meas) begin
            k = 0;
            while (!src.valid && k < 500) begin @(negedge clk); k++; end
            c = 1;
            while (!(src.valid && src.ready && src.eop) && c < 100) begin @(negedge clk); c++; end
            chk("no_bubble", c, pn);
        end
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin @(negedge clk); k++; end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("pulses", pulses - p0, exp_pulse);
        chk("overflow", int'(ovf), exp_ovf);
        chk("back_idle", int'(snk.ready), 1);
    endtask
    initial begin
        int k;
        snk.valid = 1'b0; snk.sop = 1'b0; snk.eop = 1'b0; snk.data = '0; src.ready = 1'b1;
        pmid = -1;
        repeat (3) @(negedge clk);
        chk("rst_snk_ready", int'(snk.ready), 1);
        chk("rst_src_valid", int'(src.valid), 0);
        chk("rst_sop_eop", {src.sop, src.eop}, 0);
        chk("rst_sorting", int'(sorting), 0);
        chk("rst_wren", {rw_a, rw_b}, 0);
        chk("rst_overflow", int'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        pn = 5; pkt[0] = 5; pkt[1] = 3; pkt[2] = 9; pkt[3] = 1; pkt[4] = 7;
        run_pkt(0, 1);
        chk("t1_size", got_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("t1_word", got_q[i], 2 * i + 1);
        chk("t1_maxc", last_max, 4);
        snk.valid = 1'b1; snk.sop = 1'b0; snk.eop = 1'b1; snk.data = 10'd77;
        @(negedge clk);
        snk.valid = 1'b0; snk.eop = 1'b0;
        pn = 1; pkt[0] = 42;
        run_pkt(1, 0);
        chk("t2_size", got_q.size(), 1);
        chk("t2_word", got_q[0], 42);
        pn = 2; pkt[0] = 8; pkt[1] = 2;
        run_pkt(1, 0);
        chk("t3a_lo", got_q[0], 2);
        chk("t3a_hi", got_q[1], 8);
        pkt[0] = 2; pkt[1] = 8;
        run_pkt(0, 0);
        chk("t3b_lo", got_q[0], 2);
        chk("t3b_hi", got_q[1], 8);
        pn = MAX + 3;
        for (int i = 0; i < pn; i++) pkt[i] = DW'($urandom_range(0, 1023));
        run_pkt(1, 0);
        chk("t4_overflow", int'(ovf), 1);
        chk("t4_size", got_q.size(), MAX);
        pn = 3;
        for (int i = 0; i < pn; i++) pkt[i] = DW'($urandom_range(0, 1023));
        run_pkt(0, 0);
        chk("t4_ovf_clear", int'(ovf), 0);
        rand_ready = 1;
        pn = MAX;
        for (int i = 0; i < pn; i++) pkt[i] = DW'($urandom_range(0, 1023));
        run_pkt(1, 0);
        chk("t5_size", got_q.size(), MAX);
        for (int r = 0; r < 8; r++) begin
            pn = $urandom_range(1, 20);
            pmid = ($urandom_range(0, 2) == 0) ? $urandom_range(1, pn) : -1;
            for (int i = 0; i < pn; i++) pkt[i] = DW'($urandom_range(0, 1023));
            run_pkt(1, 0);
        end
        pmid = -1;
        rand_ready = 0;
        pn = 4; pkt[0] = 6; pkt[1] = 2; pkt[2] = 9; pkt[3] = 5;
        model_pkt();
        send(0);
        k = 0;
        while (!sorting && k < 200) begin @(negedge clk); k++; end
        chk("t6_pulse", int'(sorting), 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_snk_ready", int'(snk.ready), 1);
        chk("t6_src_valid", int'(src.valid), 0);
        chk("t6_sop_eop", {src.sop, src.eop}, 0);
        chk("t6_sorting", int'(sorting), 0);
        chk("t6_wren", {rw_a, rw_b}, 0);
        chk("t6_overflow", int'(ovf), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pn = 3; pkt[0] = 4; pkt[1] = 1; pkt[2] = 3;
        run_pkt(0, 0);
        chk("t6_w0", got_q[0], 1);
        chk("t6_w1", got_q[1], 3);
        chk("t6_w2", got_q[2], 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
